// File: rtl/execute_stage.sv
// EX stage of the RV32IM pipeline: operand forwarding, ALU, branch target, PC+4,
// and an iterative 32-step multiply/divide unit that stalls upstream while it runs.
module execute_stage #(
    parameter int MDU_STEPS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        keep,
    input  logic        nop,
    input  logic        RegWrite_pype1,
    input  logic [1:0]  MemtoReg_pype1,
    input  logic [1:0]  MemRW_pype1,
    input  logic [1:0]  dsize_pype1,
    input  logic [2:0]  MemBranch_pype1,
    input  logic [4:0]  ALUop_pype1,
    input  logic        ALUSrcA_pype1,
    input  logic        ALUSrcB_pype1,
    input  logic [31:0] PC_pype1,
    input  logic [31:0] read_data1_pype1,
    input  logic [31:0] read_data2_pype1,
    input  logic [31:0] imm_pype1,
    input  logic [4:0]  WReg_pype1,
    input  logic [31:0] Instraction_pype1,
    input  logic [1:0]  fwd_a_sel,
    input  logic [1:0]  fwd_b_sel,
    input  logic [31:0] fwd_mem_data,
    input  logic [31:0] fwd_wb_data,
    output logic        ex_busy,
    output logic        RegWrite_pype2,
    output logic [1:0]  MemtoReg_pype2,
    output logic [1:0]  MemRW_pype2,
    output logic [1:0]  dsize_pype2,
    output logic [2:0]  MemBranch_pype2,
    output logic [31:0] ALU_co_pype,
    output logic [31:0] PCBranch_pype2,
    output logic [31:0] PCp4_pype2,
    output logic [31:0] read_data2_pype2,
    output logic [4:0]  WReg_pype2,
    output logic [31:0] Instraction_pype2
);

    localparam logic [2:0] MEMB_JALR = 3'd7;
    localparam int CNT_W = $clog2(MDU_STEPS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_STEPS - 1);

    typedef struct packed {
        logic        reg_write;
        logic [1:0]  mem_to_reg;
        logic [1:0]  mem_rw;
        logic [1:0]  dsize;
        logic [2:0]  mem_branch;
        logic [31:0] alu_co;
        logic [31:0] pc_branch;
        logic [31:0] pcp4;
        logic [31:0] rd2;
        logic [4:0]  wreg;
        logic [31:0] instr;
    } ex_mem_t;

    typedef enum logic [1:0] {MDU_IDLE, MDU_RUN, MDU_DONE} mdu_state_t;

    function automatic logic [31:0] alu_f(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        case (op)
            5'd0:    return a + b;
            5'd1:    return a - b;
            5'd2:    return a << b[4:0];
            5'd3:    return {31'd0, $signed(a) < $signed(b)};
            5'd4:    return {31'd0, a < b};
            5'd5:    return a ^ b;
            5'd6:    return a >> b[4:0];
            5'd7:    return 32'($signed(a) >>> b[4:0]);
            5'd8:    return a | b;
            5'd9:    return a & b;
            5'd10:   return b;
            default: return 32'd0;
        endcase
    endfunction

    // op is ALUop[2:0] of an MDU op: bit2 selects divide, bit1 remainder, 00 low product.
    function automatic logic [31:0] mdu_result(input logic [2:0] op, input logic [31:0] hi,
                                               input logic [31:0] lo, input logic [31:0] dvs,
                                               input logic negq, input logic negr);
        logic [63:0] prod;
        logic [31:0] quo;
        logic [31:0] rem;
        prod = negq ? -{hi, lo} : {hi, lo};
        quo  = (dvs == 32'd0) ? 32'hFFFF_FFFF : (negq ? -lo : lo);
        rem  = negr ? -hi : hi;
        if (!op[2]) return (op[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
        return op[1] ? rem : quo;
    endfunction

    logic [31:0] opa_fwd, opb_fwd, src_a, src_b, abs_a, abs_b, alu_res;
    logic        is_mdu, is_div, a_sgn, b_sgn, div_ge;
    logic [32:0] mul_sum, div_rs, div_diff;
    ex_mem_t     pipe_norm, pipe_d, pipe_q;
    mdu_state_t  state_d, state_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [31:0] hi_d, hi_q, lo_d, lo_q, mb_d, mb_q;
    logic [2:0]  op_d, op_q;
    logic        negq_d, negq_q, negr_d, negr_q;

    always_comb begin
        case (fwd_a_sel)
            2'd1:    opa_fwd = fwd_mem_data;
            2'd2:    opa_fwd = fwd_wb_data;
            default: opa_fwd = read_data1_pype1;
        endcase
        case (fwd_b_sel)
            2'd1:    opb_fwd = fwd_mem_data;
            2'd2:    opb_fwd = fwd_wb_data;
            default: opb_fwd = read_data2_pype1;
        endcase
        src_a   = ALUSrcA_pype1 ? PC_pype1 : opa_fwd;
        src_b   = ALUSrcB_pype1 ? imm_pype1 : opb_fwd;
        alu_res = alu_f(ALUop_pype1, src_a, src_b);
        is_mdu  = (ALUop_pype1[4:3] == 2'b10);
        is_div  = ALUop_pype1[2];
        a_sgn   = src_a[31] & (ALUop_pype1 inside {5'd16, 5'd17, 5'd18, 5'd20, 5'd22});
        b_sgn   = src_b[31] & (ALUop_pype1 inside {5'd16, 5'd17, 5'd20, 5'd22});
        abs_a   = a_sgn ? -src_a : src_a;
        abs_b   = b_sgn ? -src_b : src_b;

        pipe_norm.reg_write  = RegWrite_pype1;
        pipe_norm.mem_to_reg = MemtoReg_pype1;
        pipe_norm.mem_rw     = MemRW_pype1;
        pipe_norm.dsize      = dsize_pype1;
        pipe_norm.mem_branch = MemBranch_pype1;
        pipe_norm.alu_co     = (MemBranch_pype1 == MEMB_JALR) ? {alu_res[31:1], 1'b0} : alu_res;
        pipe_norm.pc_branch  = PC_pype1 + imm_pype1;
        pipe_norm.pcp4       = PC_pype1 + 32'd4;
        pipe_norm.rd2        = opb_fwd;
        pipe_norm.wreg       = WReg_pype1;
        pipe_norm.instr      = Instraction_pype1;
    end

    // One shift-add (multiply) or restoring-subtract (divide) step on the latched magnitudes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mb_d     = mb_q;
        op_d     = op_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        pipe_d   = pipe_q;
        mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mb_q} : 33'd0);
        div_rs   = {hi_q, lo_q[31]};
        div_diff = div_rs - {1'b0, mb_q};
        div_ge   = (div_rs >= {1'b0, mb_q});
        if (nop) begin
            pipe_d  = '0;
            state_d = MDU_IDLE;
            cnt_d   = '0;
        end else if (!keep) begin
            unique case (state_q)
                MDU_IDLE: begin
                    if (is_mdu) begin
                        pipe_d  = '0;
                        hi_d    = '0;
                        lo_d    = is_div ? abs_a : abs_b;
                        mb_d    = is_div ? abs_b : abs_a;
                        op_d    = ALUop_pype1[2:0];
                        negq_d  = a_sgn ^ b_sgn;
                        negr_d  = a_sgn;
                        cnt_d   = '0;
                        state_d = MDU_RUN;
                    end else begin
                        pipe_d = pipe_norm;
                    end
                end
                MDU_RUN: begin
                    pipe_d = '0;
                    if (op_q[2]) begin
                        hi_d = div_ge ? div_diff[31:0] : div_rs[31:0];
                        lo_d = {lo_q[30:0], div_ge};
                    end else begin
                        hi_d = mul_sum[32:1];
                        lo_d = {mul_sum[0], lo_q[31:1]};
                    end
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_d = MDU_DONE;
                end
                MDU_DONE: begin
                    pipe_d        = pipe_norm;
                    pipe_d.alu_co = mdu_result(op_q, hi_q, lo_q, mb_q, negq_q, negr_q);
                    state_d       = MDU_IDLE;
                end
                default: state_d = MDU_IDLE;
            endcase
        end
    end

    assign ex_busy = rst & (((state_q == MDU_IDLE) & is_mdu) | (state_q == MDU_RUN));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            mb_q    <= '0;
            op_q    <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            pipe_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            mb_q    <= mb_d;
            op_q    <= op_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            pipe_q  <= pipe_d;
        end
    end

    assign RegWrite_pype2    = pipe_q.reg_write;
    assign MemtoReg_pype2    = pipe_q.mem_to_reg;
    assign MemRW_pype2       = pipe_q.mem_rw;
    assign dsize_pype2       = pipe_q.dsize;
    assign MemBranch_pype2   = pipe_q.mem_branch;
    assign ALU_co_pype       = pipe_q.alu_co;
    assign PCBranch_pype2    = pipe_q.pc_branch;
    assign PCp4_pype2        = pipe_q.pcp4;
    assign read_data2_pype2  = pipe_q.rd2;
    assign WReg_pype2        = pipe_q.wreg;
    assign Instraction_pype2 = pipe_q.instr;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a driver issues instructions and queues expected
// EX/MEM contents; a negedge monitor pops and compares whenever a new instruction emerges.
module tb_execute_stage;

    localparam logic [2:0] MB_BEQ  = 3'd1;
    localparam logic [2:0] MB_JALR = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        keep = 1'b0;
    logic        nop = 1'b0;
    logic        RegWrite_pype1 = 1'b0;
    logic [1:0]  MemtoReg_pype1 = '0, MemRW_pype1 = '0, dsize_pype1 = '0;
    logic [2:0]  MemBranch_pype1 = '0;
    logic [4:0]  ALUop_pype1 = '0;
    logic        ALUSrcA_pype1 = 1'b0, ALUSrcB_pype1 = 1'b0;
    logic [31:0] PC_pype1 = '0, read_data1_pype1 = '0, read_data2_pype1 = '0, imm_pype1 = '0;
    logic [4:0]  WReg_pype1 = '0;
    logic [31:0] Instraction_pype1 = '0;
    logic [1:0]  fwd_a_sel = '0, fwd_b_sel = '0;
    logic [31:0] fwd_mem_data = '0, fwd_wb_data = '0;
    logic        ex_busy;
    logic        RegWrite_pype2;
    logic [1:0]  MemtoReg_pype2, MemRW_pype2, dsize_pype2;
    logic [2:0]  MemBranch_pype2;
    logic [31:0] ALU_co_pype, PCBranch_pype2, PCp4_pype2, read_data2_pype2;
    logic [4:0]  WReg_pype2;
    logic [31:0] Instraction_pype2;

    execute_stage #(.MDU_STEPS(32)) dut (
        .clk(clk), .rst(rst), .keep(keep), .nop(nop),
        .RegWrite_pype1(RegWrite_pype1), .MemtoReg_pype1(MemtoReg_pype1),
        .MemRW_pype1(MemRW_pype1), .dsize_pype1(dsize_pype1),
        .MemBranch_pype1(MemBranch_pype1), .ALUop_pype1(ALUop_pype1),
        .ALUSrcA_pype1(ALUSrcA_pype1), .ALUSrcB_pype1(ALUSrcB_pype1),
        .PC_pype1(PC_pype1), .read_data1_pype1(read_data1_pype1),
        .read_data2_pype1(read_data2_pype1), .imm_pype1(imm_pype1),
        .WReg_pype1(WReg_pype1), .Instraction_pype1(Instraction_pype1),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
        .ex_busy(ex_busy),
        .RegWrite_pype2(RegWrite_pype2), .MemtoReg_pype2(MemtoReg_pype2),
        .MemRW_pype2(MemRW_pype2), .dsize_pype2(dsize_pype2),
        .MemBranch_pype2(MemBranch_pype2), .ALU_co_pype(ALU_co_pype),
        .PCBranch_pype2(PCBranch_pype2), .PCp4_pype2(PCp4_pype2),
        .read_data2_pype2(read_data2_pype2), .WReg_pype2(WReg_pype2),
        .Instraction_pype2(Instraction_pype2)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [1:0]  m2r, mrw, dsz;
        logic [2:0]  mb;
        logic [4:0]  op;
        logic        asrc, bsrc;
        logic [31:0] pc, r1, r2, imm;
        logic [4:0]  wreg;
        logic [31:0] ins;
        logic [1:0]  fa, fb;
        logic [31:0] fm, fw;
    } stim_t;

    typedef struct packed {
        logic [31:0] ins, alu, pcb, pcp4, rd2;
        logic [4:0]  wreg;
        logic [9:0]  ctl;
        logic [31:0] due;
    } exp_t;

    exp_t        sbq[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] cyc = 0;
    logic [31:0] last_tag = 0;
    logic [31:0] next_tag = 1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic logic is_mdu_op(input logic [4:0] op);
        return op >= 5'd16 && op <= 5'd23;
    endfunction

    // Reference arithmetic at the level of the ISA: plain 64-bit signed/unsigned math.
    function automatic logic [31:0] ref_alu(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic signed [63:0] sa, sb, t;
        logic [63:0] ua, ub, u;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ua = {32'd0, a};
        ub = {32'd0, b};
        case (op)
            5'd0:  return a + b;
            5'd1:  return a - b;
            5'd2:  return a << b[4:0];
            5'd3:  return (sa < sb) ? 32'd1 : 32'd0;
            5'd4:  return (ua < ub) ? 32'd1 : 32'd0;
            5'd5:  return a ^ b;
            5'd6:  return a >> b[4:0];
            5'd7:  begin t = sa >>> b[4:0]; return t[31:0]; end
            5'd8:  return a | b;
            5'd9:  return a & b;
            5'd10: return b;
            5'd16: begin t = sa * sb; return t[31:0]; end
            5'd17: begin t = sa * sb; return t[63:32]; end
            5'd18: begin t = sa * $signed(ub); return t[63:32]; end
            5'd19: begin u = ua * ub; return u[63:32]; end
            5'd20: begin if (b == 0) return 32'hFFFF_FFFF; t = sa / sb; return t[31:0]; end
            5'd21: begin if (b == 0) return 32'hFFFF_FFFF; u = ua / ub; return u[31:0]; end
            5'd22: begin if (b == 0) return a; t = sa % sb; return t[31:0]; end
            5'd23: begin if (b == 0) return a; u = ua % ub; return u[31:0]; end
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] fsel(input logic [1:0] s, input logic [31:0] rf,
                                         input logic [31:0] fm, input logic [31:0] fw);
        return (s == 2'd1) ? fm : (s == 2'd2) ? fw : rf;
    endfunction

    function automatic exp_t expect_of(input stim_t s);
        exp_t e;
        logic [31:0] af, bf, a, b;
        af = fsel(s.fa, s.r1, s.fm, s.fw);
        bf = fsel(s.fb, s.r2, s.fm, s.fw);
        a = s.asrc ? s.pc : af;
        b = s.bsrc ? s.imm : bf;
        e.alu = ref_alu(s.op, a, b);
        if (s.mb == MB_JALR && !is_mdu_op(s.op)) e.alu[0] = 1'b0;
        e.ins  = s.ins;
        e.pcb  = s.pc + s.imm;
        e.pcp4 = s.pc + 32'd4;
        e.rd2  = bf;
        e.wreg = s.wreg;
        e.ctl  = {s.rw, s.m2r, s.mrw, s.dsz, s.mb};
        e.due  = 0;
        return e;
    endfunction

    function automatic stim_t mk(input logic [4:0] op, input logic [31:0] r1,
                                 input logic [31:0] r2);
        stim_t s;
        s = '0;
        s.rw = 1'b1;
        s.op = op;
        s.r1 = r1;
        s.r2 = r2;
        s.ins = next_tag;
        s.wreg = next_tag[4:0];
        next_tag = next_tag + 1;
        return s;
    endfunction

    function automatic logic [31:0] pick_val();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 40));
            default: return $urandom;
        endcase
    endfunction

    task automatic drive(input stim_t s);
        RegWrite_pype1 = s.rw;   MemtoReg_pype1 = s.m2r;  MemRW_pype1 = s.mrw;
        dsize_pype1 = s.dsz;     MemBranch_pype1 = s.mb;  ALUop_pype1 = s.op;
        ALUSrcA_pype1 = s.asrc;  ALUSrcB_pype1 = s.bsrc;  PC_pype1 = s.pc;
        read_data1_pype1 = s.r1; read_data2_pype1 = s.r2; imm_pype1 = s.imm;
        WReg_pype1 = s.wreg;     Instraction_pype1 = s.ins;
        fwd_a_sel = s.fa;        fwd_b_sel = s.fb;
        fwd_mem_data = s.fm;     fwd_wb_data = s.fw;
    endtask

    // Present one instruction, hold it while ex_busy, optionally assert keep mid-run.
    task automatic issue(input stim_t s, input int keep_n);
        exp_t e;
        int busy_n, kept, budget;
        logic bub_ok;
        drive(s);
        e = expect_of(s);
        e.due = cyc + (is_mdu_op(s.op) ? 32'd34 + 32'(keep_n) : 32'd1);
        sbq.push_back(e);
        busy_n = 0; kept = 0; budget = 200; bub_ok = 1'b1;
        while (budget > 0) begin
            @(negedge clk);
            budget--;
            if (!ex_busy) break;
            busy_n++;
            if (busy_n > 1 && (RegWrite_pype2 || Instraction_pype2 != 0)) bub_ok = 1'b0;
            @(posedge clk);
            #1;
            if (keep_n > 0 && busy_n >= 10 && kept < keep_n) begin
                keep = 1'b1;
                kept++;
            end else begin
                keep = 1'b0;
            end
        end
        keep = 1'b0;
        if (budget == 0) chk("busy_timeout", 64'(busy_n), 64'd0);
        chk("busy_cycles", 64'(busy_n), is_mdu_op(s.op) ? 64'(33 + keep_n) : 64'd0);
        if (is_mdu_op(s.op)) chk("bubble_while_busy", 64'(bub_ok), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(input int n);
        int seen, budget;
        seen = 0; budget = 200;
        while (seen < n && budget > 0) begin
            @(negedge clk);
            budget--;
            if (ex_busy) seen++;
        end
        if (seen < n) chk("wait_busy_timeout", 64'(seen), 64'(n));
    endtask

    always @(negedge clk) begin
        if (rst && Instraction_pype2 != 32'd0 && Instraction_pype2 != last_tag) begin
            last_tag = Instraction_pype2;
            if (sbq.size() == 0) begin
                chk("unexpected_output", {32'd0, Instraction_pype2}, 64'd0);
            end else begin
                mon_e = sbq.pop_front();
                chk("tag", {32'd0, Instraction_pype2}, {32'd0, mon_e.ins});
                chk("alu_co", {32'd0, ALU_co_pype}, {32'd0, mon_e.alu});
                chk("pc_branch", {32'd0, PCBranch_pype2}, {32'd0, mon_e.pcb});
                chk("pcp4", {32'd0, PCp4_pype2}, {32'd0, mon_e.pcp4});
                chk("ctl_wreg_rd2", {RegWrite_pype2, MemtoReg_pype2, MemRW_pype2, dsize_pype2,
                                     MemBranch_pype2, WReg_pype2, read_data2_pype2},
                    {mon_e.ctl, mon_e.wreg, mon_e.rd2});
                chk("latency", {32'd0, cyc}, {32'd0, mon_e.due});
            end
        end
    end

    initial begin
        stim_t s;
        // Reset state, with an MDU op already presented: ex_busy must stay low in reset.
        drive(mk(5'd16, 32'd3, 32'd4));
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", 64'(ex_busy), 64'd0);
        chk("reset_outs", {RegWrite_pype2, ALU_co_pype, Instraction_pype2, PCp4_pype2[30:0]}, 64'd0);
        drive('0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        s = mk(5'd0, 32'd99, 32'd7); s.fa = 2'd1; s.fm = 32'd5;
        issue(s, 0);
        chk("add_fwd_direct", {32'd0, ALU_co_pype}, 64'd12);
        s = mk(5'd1, 32'd9, 32'd9); s.mb = MB_BEQ; s.pc = 32'h100; s.imm = 32'h20;
        issue(s, 0);
        chk("beq_direct", {ALU_co_pype, PCBranch_pype2}, {32'd0, 32'h120});
        issue(mk(5'd16, 32'd7, 32'hFFFF_FFFD), 0);
        chk("mul_direct", {32'd0, ALU_co_pype}, 64'hFFFF_FFEB);
        issue(mk(5'd20, 32'hFFFF_FFF9, 32'd0), 0);
        chk("div_by0_direct", {32'd0, ALU_co_pype}, 64'hFFFF_FFFF);
        issue(mk(5'd22, 32'hFFFF_FFF9, 32'd0), 0);
        chk("rem_by0_direct", {32'd0, ALU_co_pype}, 64'hFFFF_FFF9);
        issue(mk(5'd20, 32'h8000_0000, 32'hFFFF_FFFF), 0);
        chk("div_ovf_direct", {32'd0, ALU_co_pype}, 64'h8000_0000);
        issue(mk(5'd22, 32'h8000_0000, 32'hFFFF_FFFF), 0);
        issue(mk(5'd21, 32'd1000, 32'd7), 5);
        issue(mk(5'd18, 32'hFFFF_FFFE, 32'hFFFF_FFFF), 0);
        issue(mk(5'd17, 32'h8000_0000, 32'h8000_0000), 0);
        issue(mk(5'd19, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0);
        issue(mk(5'd23, 32'd100, 32'd0), 0);
        s = mk(5'd0, 32'h1000, 32'd0); s.mb = MB_JALR; s.bsrc = 1'b1; s.imm = 32'd5;
        issue(s, 0);
        s = mk(5'd0, 32'd0, 32'd0); s.asrc = 1'b1; s.bsrc = 1'b1; s.pc = 32'h40; s.imm = 32'h3000;
        issue(s, 0);

        for (int i = 0; i < 60; i++) begin
            int r;
            r = $urandom_range(0, 15);
            s = mk((r < 11) ? 5'(r) : (r == 11) ? 5'd13 : 5'(16 + $urandom_range(0, 7)),
                   pick_val(), pick_val());
            s.m2r = 2'($urandom); s.mrw = 2'($urandom); s.dsz = 2'($urandom);
            s.rw = 1'($urandom);
            s.mb = is_mdu_op(s.op) ? 3'd0 : 3'($urandom);
            s.asrc = ($urandom_range(0, 3) == 0); s.bsrc = ($urandom_range(0, 3) == 0);
            s.pc = {$urandom_range(0, 65535), 2'b00}; s.imm = pick_val();
            s.fa = 2'($urandom); s.fb = 2'($urandom);
            s.fm = pick_val(); s.fw = pick_val();
            issue(s, 0);
        end

        // Flush an in-flight DIVU at cnt=10.
        drive(mk(5'd21, 32'h1234_5678, 32'd3));
        wait_busy(12);
        nop = 1'b1;
        drive('0);
        @(posedge clk);
        #1;
        nop = 1'b0;
        chk("nop_busy", 64'(ex_busy), 64'd0);
        chk("nop_outs", {RegWrite_pype2, ALU_co_pype, Instraction_pype2}, 64'd0);
        issue(mk(5'd5, 32'hF0F0_F0F0, 32'h0FF0_0FF0), 0);

        // Asynchronous reset in the middle of a multiply.
        drive(mk(5'd16, 32'd3, 32'd5));
        wait_busy(15);
        #2;
        rst = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(ex_busy), 64'd0);
        chk("rst_mid_outs", {RegWrite_pype2, ALU_co_pype, Instraction_pype2}, 64'd0);
        drive('0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(mk(5'd0, 32'd1, 32'd1), 0);
        chk("rst_add_direct", {32'd0, ALU_co_pype}, 64'd2);

        drive('0);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
